// File: rtl/r2sdf_bf_stage.sv
// Radix-2 SDF decimation-in-frequency butterfly that drives an external feedback delay line of depth N.
// Fill half: inputs go to the delay line and the previous frame's differences come out. Butterfly half: sums come out.
module r2sdf_bf_stage #(
    parameter int BW = 16,
    parameter int N  = 64,
    parameter int CW = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [BW-1:0]       in_re,
    input  logic [BW-1:0]       in_im,
    output logic                dl_shift,
    output logic [2*(BW+1)-1:0] dl_in,
    input  logic [2*(BW+1)-1:0] dl_out,
    output logic                out_valid,
    output logic [BW:0]         out_re,
    output logic [BW:0]         out_im,
    output logic                out_diff,
    output logic [CW-2:0]       out_k,
    output logic                out_sof
);

    localparam logic [CW-1:0] LP_CNT_HALF = CW'(N);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(2 * N - 1);

    logic [CW-1:0] r_cnt;
    logic          r_primed;

    logic          w_fill;
    logic [BW:0]   w_xr;
    logic [BW:0]   w_xi;
    logic [BW:0]   w_dr;
    logic [BW:0]   w_di;
    logic [BW:0]   w_sum_re;
    logic [BW:0]   w_sum_im;
    logic [BW:0]   w_dif_re;
    logic [BW:0]   w_dif_im;
    logic [BW:0]   w_cand_re;
    logic [BW:0]   w_cand_im;

    assign w_xr = {in_re[BW-1], in_re};
    assign w_xi = {in_im[BW-1], in_im};
    assign w_dr = dl_out[2*BW+1:BW+1];
    assign w_di = dl_out[BW:0];

    // BW-bit operands widened by one bit, so neither sum nor difference can wrap.
    assign w_sum_re = w_dr + w_xr;
    assign w_sum_im = w_di + w_xi;
    assign w_dif_re = w_dr - w_xr;
    assign w_dif_im = w_di - w_xi;

    assign w_fill   = (r_cnt < LP_CNT_HALF);
    assign dl_shift = in_valid;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the block leaves a latch.
        dl_in     = {w_dif_re, w_dif_im};
        w_cand_re = w_sum_re;
        w_cand_im = w_sum_im;
        if (w_fill) begin
            dl_in     = {w_xr, w_xi};
            w_cand_re = w_dr;
            w_cand_im = w_di;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_diff  <= 1'b0;
            out_k     <= '0;
            out_sof   <= 1'b0;
        end else if (in_valid) begin
            r_cnt     <= r_cnt + CW'(1);
            if (r_cnt == LP_CNT_LAST) begin
                r_primed <= 1'b1;
            end
            // Differences exist only once a whole frame has been through the delay line.
            out_valid <= !w_fill || r_primed;
            out_re    <= w_cand_re;
            out_im    <= w_cand_im;
            out_diff  <= w_fill;
            out_k     <= w_fill ? r_cnt[CW-2:0] : '0;
            out_sof   <= (r_cnt == LP_CNT_HALF);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/r2sdf_bf_stage.md
Name: r2sdf_bf_stage

Overview:
Radix-2 single-path delay-feedback (SDF) decimation-in-frequency butterfly stage for the streaming FFT pipeline. It sits directly upstream of the stage's feedback delay line (depth N, shift-on-valid, output = oldest entry). It drives the delay line's input and shift enable, and consumes the delay line's output. It emits sums and differences as a complex stream, tagged for the downstream twiddle multiplier.

Parameters:
BW, 16, input real/imag component width (signed two's complement)
N, 64, butterfly distance = feedback delay depth; power of 2, >= 2
CW, 7, counter width = log2(2*N)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid; stream advances only when high
in_re  in  BW  input real, signed
in_im  in  BW  input imag, signed
dl_shift  out  1  delay-line shift enable; combinational, = in_valid
dl_in  out  2*(BW+1)  delay-line write data {re,im}, each BW+1 signed; combinational
dl_out  in  2*(BW+1)  delay-line oldest entry {re,im}
out_valid  out  1  output sample valid (registered)
out_re  out  BW+1  output real, signed (registered)
out_im  out  BW+1  output imag, signed (registered)
out_diff  out  1  1 = output is a difference (needs twiddle); 0 = sum
out_k  out  CW-1  twiddle index for differences; 0 for sums
out_sof  out  1  first sum of a frame

Behaviour:
- Async reset (reset_n low): cnt=0, primed=0, out_valid=0, out_re/out_im=0, out_diff=0, out_k=0, out_sof=0. Delay-line contents are don't-care after reset and are never emitted before being overwritten.
- cnt: CW-bit frame position. Increments on each in_valid cycle and wraps 2N-1 -> 0. Holds when in_valid=0.
- Sign-extend in_re/in_im to BW+1 (xr, xi). Split dl_out into dr (upper half) and di (lower half).
- Fill phase (cnt < N):
  - dl_in = {xr, xi}.
  - Output candidate = {dr, di}, the previous frame's difference, with out_diff=1 and out_k = cnt[CW-2:0].
- Butterfly phase (cnt >= N):
  - Output candidate = {dr+xr, di+xi}, with out_diff=0, out_k=0, and out_sof=1 iff cnt==N.
  - dl_in = {dr-xr, di-xi}.
- No overflow is possible: operands are BW-bit values extended to BW+1. Sums and differences are taken modulo BW+1 bits (exact for BW-bit inputs); no scaling.
- Output register loads the candidate on every in_valid cycle.
  - out_valid(next) = in_valid AND (cnt >= N OR primed).
  - When in_valid=0: out_valid <= 0; data, out_diff, out_k and out_sof hold.
  - Latency: 1 clock from input sample to its sum output.
- primed is set on the in_valid cycle where cnt == 2N-1, and stays set until reset. Differences from frame f are emitted during the fill phase of frame f+1, so the last frame's differences appear only when further input is supplied. Upstream pads with zeros to flush.
- Stalls (in_valid low mid-frame): no state change, and the delay line does not shift. Alignment is preserved for any gap pattern.
- Reset mid-frame: cnt and primed return to 0 immediately (async). Partial frame output is abandoned, with no spurious out_valid after release.
- Output order per frame pair: N sums (k order), then N differences (k = 0..N-1).

Test Plan:
- N=4, BW=16. After reset, feed re = 1..8 and im = 0 continuously:
  - out_valid first high 1 clk after the 5th sample.
  - out_re = 6, 8, 10, 12 with out_sof on the 6.
  - Then feed 8 zeros: out_re = -4, -4, -4, -4 with out_diff=1, out_k = 0..3; then sums 0, 0, 0, 0.
- Extremes, N=4: frame with x0..3 = 32767 and x4..7 = 32767 (re and im):
  - sums = 65534;
  - padding frame yields diffs = 0;
  - repeat with x4..7 = -32768: diffs = 65535, sums = -1, no wrap.
- Stall robustness: same stimulus as the first scenario, with in_valid low for 3 cycles after samples 2 and 6. Output values and order are identical; out_valid is never high during a stall + 1.
- Reset mid-frame: assert reset_n low after the 6th sample. All outputs are 0 immediately. After release, a new frame 10..17 gives sums 24, 26, 28, 30, and there is no diff output before them.
- Back-to-back frames: three frames A, B, zero-pad, with random 16-bit complex data. The output stream must match a golden model exactly: sums(A), diffs(A), sums(B), diffs(B). The dl_shift count equals the in_valid count.
